// File: rtl/status_display_decoder.sv
// Time-multiplexed 4-digit 7-segment decoder for water level, irrigation mode and alarm.
// Optional decimal-point heartbeat on digit 0 when STATUS_DP_HEARTBEAT_EN is defined.
module status_display_decoder #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] encoded_water,
    input  logic [1:0] encoded_irrigation,
    input  logic       alarm,
    output logic [6:0] segments,
    output logic [3:0] digit_enable,
    output logic       displays_point
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(2 * BLINK_FRAMES);
    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_SHOW   = PW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);

    logic [PW-1:0] prescaler;
    logic [1:0]    digit;
    logic [BW-1:0] blink_count;
    logic [1:0]    snap_water;
    logic [1:0]    snap_irrigation;
    logic          snap_alarm;

    logic       slot_wrap;
    logic       frame_end;
    logic       slot_start;
    logic       slot_show;
    logic       snap_load;
    logic       alarm_rise;
    logic       phase_on;
    logic [6:0] pattern;

    assign slot_wrap  = (prescaler == PRE_LAST);
    assign frame_end  = slot_wrap && (digit == 2'd3);
    assign slot_start = (prescaler == '0);
    assign slot_show  = (prescaler == PRE_SHOW);
    assign snap_load  = slot_start && (digit == 2'd0);
    assign alarm_rise = snap_load && alarm && !snap_alarm;
    assign phase_on   = (blink_count < BLINK_HALF);

    // Active-high glyph for the digit about to be lit, from the frame snapshot only.
    always_comb begin
        // NOTE: default first so every path assigns pattern and no latch is inferred.
        pattern = 7'h00;
        case (digit)
            2'd3: begin
                case (snap_water)
                    2'd0:    pattern = 7'h3F;
                    2'd1:    pattern = 7'h06;
                    2'd2:    pattern = 7'h5B;
                    default: pattern = 7'h79;
                endcase
            end
            2'd1: begin
                case (snap_irrigation)
                    2'd0:    pattern = 7'h40;
                    2'd1:    pattern = 7'h5E;
                    2'd2:    pattern = 7'h6D;
                    default: pattern = 7'h79;
                endcase
            end
            2'd0:    pattern = (snap_alarm && phase_on) ? 7'h77 : 7'h00;
            default: pattern = 7'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            prescaler <= '0;
            digit     <= 2'd0;
        end else if (slot_wrap) begin
            prescaler <= '0;
            digit     <= digit + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap_water      <= 2'd0;
            snap_irrigation <= 2'd0;
            snap_alarm      <= 1'b0;
        end else if (snap_load) begin
            snap_water      <= encoded_water;
            snap_irrigation <= encoded_irrigation;
            snap_alarm      <= alarm;
        end
    end

    // A fresh alarm restarts the blink so it always opens with a full visible half-period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_count <= '0;
        end else if (alarm_rise) begin
            blink_count <= '0;
        end else if (frame_end) begin
            blink_count <= (blink_count == BLINK_LAST) ? '0 : blink_count + BW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            segments     <= 7'h7F;
            digit_enable <= 4'hF;
        end else if (slot_start) begin
            digit_enable <= 4'hF;
        end else if (slot_show) begin
            segments     <= ~pattern;
            digit_enable <= ~(4'b0001 << digit);
        end
    end

`ifdef STATUS_DP_HEARTBEAT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            displays_point <= 1'b1;
        end else if (slot_start) begin
            displays_point <= 1'b1;
        end else if (slot_show) begin
            displays_point <= !((digit == 2'd0) && phase_on);
        end
    end
`else
    assign displays_point = 1'b1;
`endif

endmodule

// File: tb/tb_status_display_decoder.sv
// Bench for status_display_decoder: time-indexed reference model checked every cycle,
// directed literal checks for the key scenarios, then randomized inputs and resets.
module tb_status_display_decoder;

    localparam int R  = 4;
    localparam int BF = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] encoded_water = 2'd0;
    logic [1:0] encoded_irrigation = 2'd0;
    logic       alarm = 1'b0;
    logic [6:0] segments;
    logic [3:0] digit_enable;
    logic       displays_point;

    int vectors = 0;
    int miscompares = 0;

    status_display_decoder #(.REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .encoded_water      (encoded_water),
        .encoded_irrigation (encoded_irrigation),
        .alarm              (alarm),
        .segments           (segments),
        .digit_enable       (digit_enable),
        .displays_point     (displays_point)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: everything is derived from k, the number of edges since reset release.
    logic [6:0] water_glyph [4] = '{7'h3F, 7'h06, 7'h5B, 7'h79};
    logic [6:0] irr_glyph   [4] = '{7'h40, 7'h5E, 7'h6D, 7'h79};
    int         n_edges = 0;
    int         m_water = 0;
    int         m_irr = 0;
    bit         m_alarm = 1'b0;
    int         m_clear_frame = 0;
    logic [6:0] exp_seg = 7'h7F;
    logic [3:0] exp_en = 4'hF;
    logic       exp_dp = 1'b1;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                n_edges = 0; m_water = 0; m_irr = 0; m_alarm = 1'b0; m_clear_frame = 0;
                exp_seg = 7'h7F; exp_en = 4'hF; exp_dp = 1'b1;
            end else begin
                int k, pre, d, f;
                bit on;
                k   = n_edges;
                n_edges++;
                pre = k % R;
                d   = (k / R) % 4;
                f   = k / (4 * R);
                if (pre == 0) begin
                    exp_en = 4'hF;
                    exp_dp = 1'b1;
                    if (d == 0) begin
                        if (alarm && !m_alarm) m_clear_frame = f;
                        m_water = int'(encoded_water);
                        m_irr   = int'(encoded_irrigation);
                        m_alarm = alarm;
                    end
                end else if (pre == 1) begin
                    on = ((f - m_clear_frame) % (2 * BF)) < BF;
                    case (d)
                        3:       exp_seg = ~water_glyph[m_water];
                        1:       exp_seg = ~irr_glyph[m_irr];
                        0:       exp_seg = (m_alarm && on) ? ~7'h77 : 7'h7F;
                        default: exp_seg = 7'h7F;
                    endcase
                    exp_en = ~(4'b0001 << d);
`ifdef STATUS_DP_HEARTBEAT_EN
                    exp_dp = !(d == 0 && on);
`else
                    exp_dp = 1'b1;
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            check("model_segments", 32'(segments), 32'(exp_seg));
            check("model_digit_enable", 32'(digit_enable), 32'(exp_en));
            check("model_point", 32'(displays_point), 32'(exp_dp));
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    logic exp_dp_lit;

    initial begin
`ifdef STATUS_DP_HEARTBEAT_EN
        exp_dp_lit = 1'b0;
`else
        exp_dp_lit = 1'b1;
`endif
        encoded_water = 2'd2; encoded_irrigation = 2'd2; alarm = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        step(1);  check("edge1_blank", 32'(digit_enable), 32'hF);
        step(1);  check("edge2_d0_en", 32'(digit_enable), 32'hE);
                  check("edge2_d0_seg", 32'(segments), 32'h7F);
        step(3);  check("slot1_start_blank", 32'(digit_enable), 32'hF);
        step(1);  check("d1_sprinkler", 32'(segments), 32'h12);
                  check("d1_en", 32'(digit_enable), 32'hD);
        step(4);  check("d2_blank_seg", 32'(segments), 32'h7F);
                  check("d2_en", 32'(digit_enable), 32'hB);
        step(4);  check("d3_high", 32'(segments), 32'h24);
                  check("d3_en", 32'(digit_enable), 32'h7);
        encoded_water = 2'd1;
        step(12); encoded_water = 2'd3;
        step(5);  check("d3_mid_frame_hold", 32'(segments), 32'h79);
        step(16); check("d3_error_next_frame", 32'(segments), 32'h06);
        alarm = 1'b1;
        step(3);  check("alarm_f3_on", 32'(segments), 32'h08);
                  check("alarm_f3_point", 32'(displays_point), 32'(exp_dp_lit));
        step(16); check("alarm_f4_on", 32'(segments), 32'h08);
        step(16); check("alarm_f5_off", 32'(segments), 32'h7F);
                  check("alarm_f5_point", 32'(displays_point), 32'h1);
        step(16); check("alarm_f6_off", 32'(segments), 32'h7F);
        step(16); check("alarm_f7_on", 32'(segments), 32'h08);
        alarm = 1'b0;
        step(16); check("alarm_dropped", 32'(segments), 32'h7F);
        alarm = 1'b1;
        step(16); check("alarm_restart_f9", 32'(segments), 32'h08);
        step(16); check("alarm_restart_f10", 32'(segments), 32'h08);
        step(16); check("alarm_restart_f11", 32'(segments), 32'h7F);
        encoded_irrigation = 2'd0; encoded_water = 2'd0;
        step(20); check("d1_off_dash", 32'(segments), 32'h3F);
        step(8);  check("d3_low", 32'(segments), 32'h40);
        encoded_irrigation = 2'd3;
        step(8);  check("d1_error", 32'(segments), 32'h06);
        step(5);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_seg", 32'(segments), 32'h7F);
        check("async_reset_en", 32'(digit_enable), 32'hF);
        check("async_reset_point", 32'(displays_point), 32'h1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        step(1);  check("rerelease_edge1", 32'(digit_enable), 32'hF);
        step(1);  check("rerelease_edge2", 32'(digit_enable), 32'hE);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            #2;
            if ($urandom_range(0, 19) == 0) encoded_water = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) encoded_irrigation = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) alarm = ~alarm;
            if ($urandom_range(0, 699) == 0) begin
                reset_n = 1'b0;
                @(negedge clock);
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
